// File: rtl/pid_controller_param_if.sv
// Sample/result handshake bundle for pid_controller_param.
// The master drives samples and gains; the slave (controller) returns the clamped result.
interface pid_controller_param_if #(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 8
);
  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] setpoint;
  logic [DATA_W-1:0] feedback;
  logic [GAIN_W-1:0] kp;
  logic [GAIN_W-1:0] ki;
  logic [GAIN_W-1:0] kd;
  logic              clear_int;
  logic [DATA_W-1:0] control_out;
  logic              out_valid;
  logic              saturated;

  modport master (
    output sample_valid, setpoint, feedback, kp, ki, kd, clear_int,
    input  sample_ready, control_out, out_valid, saturated
  );
  modport slave (
    input  sample_valid, setpoint, feedback, kp, ki, kd, clear_int,
    output sample_ready, control_out, out_valid, saturated
  );
endinterface

// File: rtl/pid_controller_param.sv
// Sequential fixed-point PID: one sample every 6 cycles, one term per state,
// saturating integrator with anti-windup and an output clamped to [0, 2^DATA_W-1].
module pid_controller_param #(
  parameter int DATA_W = 8,
  parameter int GAIN_W = 8,
  parameter int FRAC_W = 4,
  parameter int INT_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic clk,
  input  logic rst_n,
  pid_controller_param_if.slave bus
);
  localparam int EW = DATA_W + 1;
  localparam int DW = DATA_W + 2;
  localparam logic signed [INT_W:0]   INT_LIM = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, ERR, PTERM, ITERM, DTERM, SUM} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0]       sp_q, fb_q;
  logic [GAIN_W-1:0]       kp_q, ki_q, kd_q;
  logic signed [EW-1:0]    e, prev_e, e_c;
  logic signed [DW-1:0]    diff;
  logic signed [INT_W-1:0] integ, integ_sat, integ_nx;
  logic signed [INT_W:0]   isum;
  logic signed [ACC_W-1:0] p_term, i_term, d_term, kp_x, ki_x, kd_x;
  logic signed [ACC_W+1:0] tsum;
  logic signed [ACC_W-1:0] acc_sat, shifted;
  logic [DATA_W-1:0]       out_c;
  logic                    clamp_hi, clamp_lo, sat_hi, sat_lo, hold, accept;

  assign bus.sample_ready = (state == IDLE);
  assign accept = bus.sample_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.sample_valid) state_nx = ERR;
      ERR:     state_nx = PTERM;
      PTERM:   state_nx = ITERM;
      ITERM:   state_nx = DTERM;
      DTERM:   state_nx = SUM;
      SUM:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gains are unsigned; widen with a zero sign bit so products stay signed.
  assign kp_x = ACC_W'($signed({1'b0, kp_q}));
  assign ki_x = ACC_W'($signed({1'b0, ki_q}));
  assign kd_x = ACC_W'($signed({1'b0, kd_q}));
  assign e_c  = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});

  always_comb begin
    isum = (INT_W+1)'(integ) + (INT_W+1)'(e);
    if (isum > INT_LIM)       integ_sat = INT_W'(INT_LIM);
    else if (isum < -INT_LIM) integ_sat = INT_W'(-INT_LIM);
    else                      integ_sat = isum[INT_W-1:0];
    // Anti-windup: don't push further into a rail the last result already hit.
    hold = (sat_hi && !e[EW-1] && (e != '0)) || (sat_lo && e[EW-1]);
    integ_nx = hold ? integ : integ_sat;
  end

  always_comb begin
    tsum = (ACC_W+2)'(p_term) + (ACC_W+2)'(i_term) + (ACC_W+2)'(d_term);
    if (tsum > ACC_MAX)      acc_sat = ACC_W'(ACC_MAX);
    else if (tsum < ACC_MIN) acc_sat = ACC_W'(ACC_MIN);
    else                     acc_sat = tsum[ACC_W-1:0];
    shifted  = acc_sat >>> FRAC_W;
    clamp_hi = 1'b0;
    clamp_lo = 1'b0;
    out_c    = shifted[DATA_W-1:0];
    if (shifted[ACC_W-1]) begin
      out_c = '0;  clamp_lo = 1'b1;
    end else if (shifted > OUT_MAX) begin
      out_c = '1;  clamp_hi = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0; fb_q <= '0; kp_q <= '0; ki_q <= '0; kd_q <= '0;
      e <= '0; prev_e <= '0; diff <= '0; integ <= '0;
      p_term <= '0; i_term <= '0; d_term <= '0;
      bus.control_out <= '0; bus.out_valid <= 1'b0; bus.saturated <= 1'b0;
      sat_hi <= 1'b0; sat_lo <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear_int) begin
            integ  <= '0;
            prev_e <= '0;
          end
          if (accept) begin
            sp_q <= bus.setpoint; fb_q <= bus.feedback;
            kp_q <= bus.kp; ki_q <= bus.ki; kd_q <= bus.kd;
          end
        end
        ERR: begin
          e    <= e_c;
          diff <= DW'(e_c) - DW'(prev_e);
        end
        PTERM: p_term <= kp_x * ACC_W'(e);
        ITERM: begin
          integ  <= integ_nx;
          i_term <= ki_x * ACC_W'(integ_nx);
        end
        DTERM: begin
          d_term <= kd_x * ACC_W'(diff);
          prev_e <= e;
        end
        SUM: begin
          bus.control_out <= out_c;
          bus.out_valid   <= 1'b1;
          bus.saturated   <= clamp_hi | clamp_lo;
          sat_hi          <= clamp_hi;
          sat_lo          <= clamp_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_controller_param.sv
// Bench for pid_controller_param: vector table plus hand sequences for
// back-to-back throughput and reset during a computation; results go through a scoreboard.
module tb_pid_controller_param;
  logic clk, rst_n;
  int errors = 0, checks = 0;

  pid_controller_param_if #(.DATA_W(8), .GAIN_W(8)) bus();
  pid_controller_param #(.DATA_W(8), .GAIN_W(8), .FRAC_W(4), .INT_W(16), .ACC_W(32))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr;
    logic [7:0] sp, fb, kp, ki, kd, out;
    logic       sat;
  } vec_t;
  typedef struct packed { logic [7:0] out; logic sat; } exp_t;

  exp_t sb[$];
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("control_out", bus.control_out, x.out);
        chk("saturated", bus.saturated, x.sat);
      end
    end
  end

  task automatic load(input vec_t v);
    bus.setpoint = v.sp; bus.feedback = v.fb;
    bus.kp = v.kp; bus.ki = v.ki; bus.kd = v.kd;
    bus.clear_int = v.clr;
  endtask

  task automatic wait_out(input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(nm, lat, 5);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    load(v);
    bus.sample_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{out: v.out, sat: v.sat});
    #1 bus.sample_valid = 1'b0; bus.clear_int = 1'b0;
    wait_out({nm, "_latency"});
    @(negedge clk);
    chk({nm, "_one_pulse"}, bus.out_valid, 0);
  endtask

  initial begin
    int seen;
    //            clr  sp   fb   kp    ki    kd    out  sat
    tbl[0]  = '{1'b1, 100,  40, 8'h10, 8'h00, 8'h00,  60, 1'b0};
    tbl[1]  = '{1'b0,  10,  50, 8'h10, 8'h00, 8'h00,   0, 1'b1};
    tbl[2]  = '{1'b1,  20,  10, 8'h00, 8'h10, 8'h00,  10, 1'b0};
    tbl[3]  = '{1'b0,  20,  10, 8'h00, 8'h10, 8'h00,  20, 1'b0};
    tbl[4]  = '{1'b0,  20,  10, 8'h00, 8'h10, 8'h00,  30, 1'b0};
    tbl[5]  = '{1'b1,  20,  10, 8'h00, 8'h10, 8'h00,  10, 1'b0};
    tbl[6]  = '{1'b1,  50,   0, 8'h00, 8'h00, 8'h10,  50, 1'b0};
    tbl[7]  = '{1'b0,  50,   0, 8'h00, 8'h00, 8'h10,   0, 1'b0};
    tbl[8]  = '{1'b1, 255,   0, 8'h40, 8'h01, 8'h00, 255, 1'b1};
    tbl[9]  = '{1'b0, 255,   0, 8'h40, 8'h01, 8'h00, 255, 1'b1};
    tbl[10] = '{1'b0, 255,   0, 8'h40, 8'h01, 8'h00, 255, 1'b1};
    tbl[11] = '{1'b0, 255,   0, 8'h40, 8'h01, 8'h00, 255, 1'b1};
    // integ held at 255 by anti-windup: 16*255>>4 = 255 exactly, not clamped
    tbl[12] = '{1'b0,   0,   0, 8'h00, 8'h10, 8'h00, 255, 1'b0};

    rst_n = 1'b0;
    bus.sample_valid = 1'b0; bus.clear_int = 1'b0;
    bus.setpoint = '0; bus.feedback = '0; bus.kp = '0; bus.ki = '0; bus.kd = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_control_out", bus.control_out, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_saturated", bus.saturated, 0);
    chk("rst_sample_ready", bus.sample_ready, 1);

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    repeat (4) @(negedge clk);
    chk("hold_control_out", bus.control_out, 255);
    chk("hold_saturated", bus.saturated, 0);

    // Back-to-back: valid held high, second accept lands in the out_valid cycle.
    @(negedge clk);
    load(tbl[0]);
    bus.sample_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{out: 8'd60, sat: 1'b0});
    #1 bus.clear_int = 1'b0;
    wait_out("b2b_first_latency");
    chk("b2b_ready_at_pulse", bus.sample_ready, 1);
    @(posedge clk);
    sb.push_back('{out: 8'd60, sat: 1'b0});
    #1 bus.sample_valid = 1'b0;
    wait_out("b2b_second_latency");

    // Reset pulsed while the controller sits in DTERM.
    @(negedge clk);
    load(tbl[12]);
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_control_out", bus.control_out, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_sample_ready", bus.sample_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("midrst_no_pulse", seen, 0);
    chk("midrst_out_after", bus.control_out, 0);
    // Integrator restarts from zero after reset.
    run_vec('{1'b0, 8'd20, 8'd10, 8'h00, 8'h10, 8'h00, 8'd10, 1'b0}, "post_rst");

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pid_controller_param.md
PID_CONTROLLER_PARAM -- requirements
Module: pid_controller_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the setpoint/feedback/output width in bits.
REQ-002 The block SHALL have parameter GAIN_W, default 8, the width of unsigned gains kp/ki/kd.
REQ-003 The block SHALL have parameter FRAC_W, default 4, the gain fraction bits (default gains are Q4.4).
REQ-004 The block SHALL have parameter INT_W, default 16, the signed integrator width; limit INT_LIM = 2^(INT_W-1)-1.
REQ-005 The block SHALL have parameter ACC_W, default 32, the signed width of product and sum registers.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port sample_valid, input, 1 bit, a new setpoint/feedback pair is offered.
REQ-009 The block SHALL have port sample_ready, output, 1 bit, high exactly when in state IDLE.
REQ-010 The block SHALL have ports setpoint and feedback, input, DATA_W bits each, unsigned.
REQ-011 The block SHALL have ports kp, ki, kd, input, GAIN_W bits each, unsigned fixed-point gains.
REQ-012 The block SHALL have port clear_int, input, 1 bit, clears integrator and previous error.
REQ-013 The block SHALL have port control_out, output, DATA_W bits, the registered clamped result.
REQ-014 The block SHALL have port out_valid, output, 1 bit, a one-cycle pulse when control_out updates.
REQ-015 The block SHALL have port saturated, output, 1 bit, set when the last result was clamped.

Function
REQ-016 A sample SHALL be accepted on an edge with sample_valid=1 and sample_ready=1; setpoint, feedback, kp, ki and kd are latched then.
REQ-017 The FSM SHALL step IDLE -> ERR -> PTERM -> ITERM -> DTERM -> SUM -> IDLE, one state per cycle, with no stalls.
REQ-018 ERR SHALL compute e = setpoint - feedback as signed DATA_W+1 bits and diff = e - prev_e as signed DATA_W+2 bits.
REQ-019 PTERM SHALL compute kp*e, sign-extended to ACC_W.
REQ-020 ITERM SHALL set integ = sat(integ + e) to [-INT_LIM, +INT_LIM], then compute ki*integ.
REQ-021 Anti-windup SHALL hold integ unchanged when the previous result clamped high and e > 0, or clamped low and e < 0.
REQ-022 DTERM SHALL compute kd*diff and set prev_e = e.
REQ-023 SUM SHALL add the three terms saturating at ACC_W, shift right arithmetically by FRAC_W, and clamp to [0, 2^DATA_W-1].
REQ-024 On the SUM -> IDLE edge, control_out SHALL load the clamped value, out_valid SHALL be 1 for that one cycle, and saturated SHALL be set to 1 if clamping occurred, else 0.
REQ-025 Latency SHALL be fixed: if a sample is accepted at edge N, out_valid is high in the cycle after edge N+5.
REQ-026 A new sample MAY be accepted in the same cycle out_valid is high, giving a throughput of one sample per 6 cycles.
REQ-027 clear_int SHALL be sampled only while sample_ready=1; in busy states it SHALL be ignored.
REQ-028 If clear_int=1 with no accept, integ and prev_e SHALL be zeroed on that edge.
REQ-029 If clear_int=1 coincides with an accept, integ and prev_e SHALL be zeroed first, so the sample integrates from 0 and diff = e.
REQ-030 control_out and saturated SHALL hold their values between out_valid pulses.
REQ-031 sample_valid while busy SHALL be ignored, with no queuing.

Reset
REQ-032 While rst_n=0, regardless of state, the block SHALL be in IDLE with control_out=0, out_valid=0, saturated=0, sample_ready=1, integ=0, prev_e=0, all terms 0.
REQ-033 Reset asserted mid-computation SHALL abort the computation with no out_valid pulse; the first accept after release starts from the reset state.

Verification
REQ-034 The bench SHALL cover release from reset: control_out=0, out_valid=0, saturated=0, sample_ready=1.
REQ-035 The bench SHALL cover the P path: kp=0x10, ki=kd=0, setpoint=100, feedback=40 -> control_out=60, saturated=0, and out_valid pulses exactly once, 6th cycle after accept.
REQ-036 The bench SHALL cover the low clamp: kp=0x10, setpoint=10, feedback=50 -> control_out=0, saturated=1.
REQ-037 The bench SHALL cover the I path: ki=0x10, kp=kd=0, setpoint=20, feedback=10, three samples -> 10, 20, 30; then clear_int with a fourth sample -> 10.
REQ-038 The bench SHALL cover the D path: kd=0x10, kp=ki=0, setpoint=50, feedback=0, two samples -> 50, then 0.
REQ-039 The bench SHALL cover anti-windup and reset: kp=0x40, ki=0x01, setpoint=255, feedback=0, four samples -> 255 with saturated=1 and integ stuck at 255; then kp=0, ki=0x10, setpoint=feedback=0 -> 255; and rst_n pulsed low in DTERM -> no out_valid, control_out=0.
